// File: rtl/reset_sync_seq.sv
// Reset synchronizer and release sequencer: asynchronous assertion, synchronized
// deassertion, hold-off, then staggered release of NUM_OUT active-low resets.
module reset_sync_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_OUT     = 3,
  parameter int STAGGER     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               rst_done,
  output logic [1:0]         rst_state
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_n;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [NUM_OUT-1:0]     release_mask;

  // Deassertion of rst only reaches the FSM after crossing the whole chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

  always_comb begin
    release_mask = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == IW'(i)) begin
        release_mask[i] = 1'b1;
      end
    end
  end

  // Software request overrides any in-flight progress and restarts at HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      idx       <= '0;
      rst_out_n <= '0;
      rst_done  <= 1'b0;
    end else if (sw_rst_req && (state != ST_ASSERT)) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_out_n <= '0;
      rst_done  <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (sync_rst_n) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out_n[0] <= 1'b1;
            idx          <= IW'(1);
            cnt          <= '0;
            if (NUM_OUT == 1) begin
              state    <= ST_DONE;
              rst_done <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == STAG_LAST) begin
            rst_out_n <= rst_out_n | release_mask;
            idx       <= idx + IW'(1);
            cnt       <= '0;
            if (idx == IDX_LAST) begin
              state    <= ST_DONE;
              rst_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

  assign rst_state = state;

endmodule

// File: tb/tb_reset_sync_seq.sv
// Self-checking bench for reset_sync_seq: directed scenarios on three parameter
// sets plus randomized rst/sw_rst_req traffic against an edge-count timing model.
module tb_reset_sync_seq;

  localparam int SYNC_P [3] = '{2, 3, 2};
  localparam int HOLD_P [3] = '{4, 1, 4};
  localparam int NUM_P  [3] = '{3, 1, 4};
  localparam int STAG_P [3] = '{2, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_rst_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] out0;
  logic [0:0] out1;
  logic [3:0] out2;
  logic       done0, done1, done2;
  logic [1:0] st0, st1, st2;

  logic [3:0] obs_out   [3];
  logic       obs_done  [3];
  logic [1:0] obs_state [3];

  always #5 clk = ~clk;

  reset_sync_seq dut0 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .rst_out_n(out0), .rst_done(done0), .rst_state(st0)
  );

  reset_sync_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_OUT(1), .STAGGER(1)) dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .rst_out_n(out1), .rst_done(done1), .rst_state(st1)
  );

  reset_sync_seq #(.NUM_OUT(4), .STAGGER(3)) dut2 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .rst_out_n(out2), .rst_done(done2), .rst_state(st2)
  );

  assign obs_out[0]   = {1'b0, out0};
  assign obs_out[1]   = {3'b000, out1};
  assign obs_out[2]   = out2;
  assign obs_done[0]  = done0;
  assign obs_done[1]  = done1;
  assign obs_done[2]  = done2;
  assign obs_state[0] = st0;
  assign obs_state[1] = st1;
  assign obs_state[2] = st2;

  // Model: mk counts edges since rst released; mbase is the edge HOLD began.
  int mk    [3] = '{0, 0, 0};
  int mbase [3] = '{3, 4, 3};

  function automatic int model_state(int n);
    int d;
    if (mk[n] < mbase[n]) return 0;
    d = mk[n] - mbase[n];
    if (d < HOLD_P[n]) return 1;
    if (d >= HOLD_P[n] + (NUM_P[n] - 1) * STAG_P[n]) return 3;
    return 2;
  endfunction

  function automatic logic [3:0] model_out(int n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NUM_P[n]; i++) begin
      if (mk[n] >= mbase[n] && (mk[n] - mbase[n]) >= HOLD_P[n] + i * STAG_P[n]) r[i] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst) begin
        mk[n]    <= 0;
        mbase[n] <= SYNC_P[n] + 1;
      end else begin
        if (sw_rst_req && model_state(n) != 0) mbase[n] <= mk[n] + 1;
        mk[n] <= mk[n] + 1;
      end
    end
  end

  function automatic logic [2:0] exp_def_out(int e);
    if (e >= 11) return 3'b111;
    if (e >= 9) return 3'b011;
    if (e >= 7) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] exp_def_state(int e);
    if (e >= 11) return 2'd3;
    if (e >= 7) return 2'd2;
    if (e >= 3) return 2'd1;
    return 2'd0;
  endfunction

  // Leaves rst released between edges, so the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (out0 !== 3'b000 || done0 !== 1'b0 || st0 !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_immediate: got out=%b done=%b state=%0d, expected out=000 done=0 state=0", out0, done0, st0);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out1 !== 1'b0 || out2 !== 4'b0000 || done1 !== 1'b0 || done2 !== 1'b0 || st1 !== 2'd0 || st2 !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got out1=%b out2=%b done1=%b done2=%b st1=%0d st2=%0d, expected all zero", out1, out2, done1, done2, st1, st2);
    end
  endtask

  task automatic test_powerup();
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e <= 2) begin
        vectors++;
        if (dut0.sync_rst_n !== (e == 2)) begin
          miscompares++;
          $display("[TB] FAIL powerup_sync edge %0d: got %b expected %b", e, dut0.sync_rst_n, (e == 2));
        end
      end
      vectors++;
      if (out0 !== exp_def_out(e) || st0 !== exp_def_state(e) || done0 !== (e >= 11)) begin
        miscompares++;
        $display("[TB] FAIL powerup edge %0d: got out=%b state=%0d done=%b, expected out=%b state=%0d done=%b",
                 e, out0, st0, done0, exp_def_out(e), exp_def_state(e), (e >= 11));
      end
    end
  endtask

  task automatic test_async_mid_release();
    do_reset();
    for (int e = 1; e <= 8; e++) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (out0 !== 3'b000 || done0 !== 1'b0 || st0 !== 2'd0 || out2 !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL async_abort: got out=%b done=%b state=%0d out2=%b, expected out=000 done=0 state=0 out2=0000",
               out0, done0, st0, out2);
    end
    #1 rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out0 !== exp_def_out(e) || st0 !== exp_def_state(e) || done0 !== (e >= 11)) begin
        miscompares++;
        $display("[TB] FAIL async_rerun edge %0d: got out=%b state=%0d done=%b, expected out=%b state=%0d done=%b",
                 e, out0, st0, done0, exp_def_out(e), exp_def_state(e), (e >= 11));
      end
    end
  endtask

  task automatic test_sw_done();
    logic [2:0] eo;
    logic [1:0] es;
    int d;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (e == 19) sw_rst_req = 1'b1;
      if (e == 20) sw_rst_req = 1'b0;
      @(negedge clk);
      if (e < 20) begin
        eo = exp_def_out(e);
        es = exp_def_state(e);
      end else begin
        d  = e - 20;
        eo = (d >= 8) ? 3'b111 : (d >= 6) ? 3'b011 : (d >= 4) ? 3'b001 : 3'b000;
        es = (d >= 8) ? 2'd3 : (d >= 4) ? 2'd2 : 2'd1;
      end
      if (e >= 18) begin
        vectors++;
        if (out0 !== eo || st0 !== es || done0 !== (es == 2'd3)) begin
          miscompares++;
          $display("[TB] FAIL sw_done edge %0d: got out=%b state=%0d done=%b, expected out=%b state=%0d done=%b",
                   e, out0, st0, done0, eo, es, (es == 2'd3));
        end
      end
    end
  endtask

  task automatic test_sw_edge();
    logic [2:0] eo;
    do_reset();
    sw_rst_req = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) sw_rst_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (st0 !== exp_def_state(e) || out0 !== exp_def_out(e)) begin
        miscompares++;
        $display("[TB] FAIL sw_in_assert edge %0d: got state=%0d out=%b, expected state=%0d out=%b",
                 e, st0, out0, exp_def_state(e), exp_def_out(e));
      end
    end
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) sw_rst_req = 1'b1;
      if (e == 6) sw_rst_req = 1'b0;
      @(negedge clk);
      eo = (e >= 14) ? 3'b111 : (e >= 12) ? 3'b011 : (e >= 10) ? 3'b001 : 3'b000;
      vectors++;
      if (out0 !== eo || done0 !== (e >= 14)) begin
        miscompares++;
        $display("[TB] FAIL sw_in_hold edge %0d: got out=%b done=%b, expected out=%b done=%b", e, out0, done0, eo, (e >= 14));
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 1; e <= 12; e++) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (out0 !== 3'b000 || out1 !== 1'b0 || out2 !== 4'b0000 || done0 !== 1'b0 || done1 !== 1'b0 || done2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL glitch_assert: got out0=%b out1=%b out2=%b done=%b%b%b, expected all zero",
               out0, out1, out2, done0, done1, done2);
    end
    #1 rst = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out0 !== exp_def_out(e) || done0 !== (e >= 11)) begin
        miscompares++;
        $display("[TB] FAIL glitch_rerun edge %0d: got out=%b done=%b, expected out=%b done=%b",
                 e, out0, done0, exp_def_out(e), (e >= 11));
      end
    end
  endtask

  task automatic test_param_sweep();
    int nrel;
    logic [3:0] e2;
    logic [1:0] es1;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      es1 = (e >= 5) ? 2'd3 : (e >= 4) ? 2'd1 : 2'd0;
      vectors++;
      if (out1 !== (e >= 5) || done1 !== (e >= 5) || st1 !== es1) begin
        miscompares++;
        $display("[TB] FAIL sweep_single edge %0d: got out=%b done=%b state=%0d, expected out=%b done=%b state=%0d",
                 e, out1, done1, st1, (e >= 5), (e >= 5), es1);
      end
      nrel = (e < 7) ? 0 : ((e - 7) / 3 + 1);
      if (nrel > 4) nrel = 4;
      e2 = 4'((1 << nrel) - 1);
      vectors++;
      if (out2 !== e2 || done2 !== (nrel == 4)) begin
        miscompares++;
        $display("[TB] FAIL sweep_stagger edge %0d: got out=%b done=%b, expected out=%b done=%b", e, out2, done2, e2, (nrel == 4));
      end
      vectors++;
      if ((out2 & (out2 + 4'd1)) !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL sweep_monotonic edge %0d: got out=%b, expected contiguous low ones", e, out2);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      r = int'($urandom_range(0, 99));
      sw_rst_req = (r < 8);
      if (r == 99) begin
        rst = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
          vectors++;
          if (obs_out[n] !== model_out(n) || obs_done[n] !== 1'b0 || obs_state[n] !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL random_async dut%0d: got out=%b done=%b state=%0d, expected out=%b done=0 state=0",
                     n, obs_out[n], obs_done[n], obs_state[n], model_out(n));
          end
        end
        if ($urandom_range(0, 1) == 1) #1 rst = 1'b1;
      end else if (!rst && $urandom_range(0, 3) == 0) begin
        rst = 1'b1;
      end
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        vectors++;
        if (obs_out[n] !== model_out(n) || obs_done[n] !== (model_state(n) == 3) || obs_state[n] !== 2'(model_state(n))) begin
          miscompares++;
          $display("[TB] FAIL random cycle %0d dut%0d: got out=%b done=%b state=%0d, expected out=%b done=%b state=%0d",
                   c, n, obs_out[n], obs_done[n], obs_state[n], model_out(n), (model_state(n) == 3), model_state(n));
        end
      end
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_async_mid_release();
    test_sw_done();
    test_sw_edge();
    test_glitch();
    test_param_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
